// File: rtl/equihash_result_tx_if.sv
// Stream bundle for the host return path: source drives payload/framing,
// sink drives rdy.
interface if_axi_stream #(
    parameter int DAT_BYTS = 8
);
    logic                        val;
    logic                        rdy;
    logic                        sop;
    logic                        eop;
    logic [DAT_BYTS*8-1:0]       dat;
    logic [$clog2(DAT_BYTS)-1:0] mod;
    logic                        ctl;
    logic                        err;

    modport master (output val, sop, eop, dat, mod, ctl, err, input rdy);
    modport slave  (input val, sop, eop, dat, mod, ctl, err, output rdy);
endinterface

// File: rtl/equihash_result_tx.sv
// Queues verifier results and sends each as a two-beat reply packet
// {length, type} then {seq, mask}.
module equihash_result_tx #(
    parameter int          DAT_BYTS  = 8,
    parameter int          MASK_BITS = 8,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] MSG_TYPE  = 32'h0000_0002
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [MASK_BITS-1:0]   i_mask,
    input  logic                   i_mask_val,
    if_axi_stream.master           o_axi,
    output logic                   o_overflow,
    output logic [$clog2(DEPTH):0] o_pending
);
    localparam int          AW       = $clog2(DEPTH);
    localparam int          DW       = DAT_BYTS * 8;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    typedef struct packed {
        logic [31:0]          seq;
        logic [MASK_BITS-1:0] mask;
    } entry_t;

    typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

    state_t          state_q, state_d;
    entry_t          mem_q [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     cnt_q;
    logic [31:0]     seq_q;
    logic            ovf_q;
    logic            armed_q;
    logic            strobe, push, pop;
    logic [DW-1:0]   dat_d;

    // armed_q masks the strobe in the first cycle after reset release
    assign strobe = i_mask_val && armed_q;
    assign pop    = (state_q == BODY) && o_axi.rdy;
    // A full FIFO still takes the push when the head leaves this same cycle
    assign push   = strobe && ((cnt_q != FULL_CNT) || pop);
    assign head   = mem_q[rd_q];

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_q] <= {seq_q, i_mask};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            seq_q   <= '0;
            ovf_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            if (strobe)         seq_q <= seq_q + 32'd1;
            if (strobe && !push) ovf_q <= 1'b1;
            if (push)           wr_q  <= wr_q + 1'b1;
            if (pop)            rd_q  <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + ONE_CNT;
                2'b01:   cnt_q <= cnt_q - ONE_CNT;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        dat_d   = '0;
        case (state_q)
            IDLE: if (cnt_q != '0) state_d = HDR;
            HDR: begin
                dat_d[63:0] = {MSG_TYPE, 32'd16};
                if (o_axi.rdy) state_d = BODY;
            end
            BODY: begin
                dat_d[31:0]           = head.seq;
                dat_d[32 +: MASK_BITS] = head.mask;
                if (o_axi.rdy) state_d = ((cnt_q > ONE_CNT) || push) ? HDR : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_axi.val  = (state_q != IDLE);
    assign o_axi.sop  = (state_q == HDR);
    assign o_axi.eop  = (state_q == BODY);
    assign o_axi.dat  = dat_d;
    assign o_axi.mod  = '0;
    assign o_axi.ctl  = 1'b0;
    assign o_axi.err  = 1'b0;
    assign o_overflow = ovf_q;
    assign o_pending  = cnt_q;
endmodule

// File: tb/tb_equihash_result_tx.sv
// Bench for equihash_result_tx: directed tables/sequences plus a randomized
// run against a queue-based reference model.
module tb_equihash_result_tx;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] mask  = '0;
    logic       mval  = 1'b0;
    logic       ovf;
    logic [2:0] pend;
    int         tests = 0;
    int         fails = 0;

    localparam logic [63:0] HDR_DAT = 64'h0000_0002_0000_0010;

    if_axi_stream #(.DAT_BYTS(8)) axi ();

    equihash_result_tx #(
        .DAT_BYTS(8), .MASK_BITS(8), .DEPTH(4), .MSG_TYPE(32'h0000_0002)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_mask(mask), .i_mask_val(mval),
        .o_axi(axi), .o_overflow(ovf), .o_pending(pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  m;
        logic [63:0] b1;
    } vec_t;

    function automatic logic [63:0] body(input logic [31:0] s, input logic [7:0] m);
        return {24'h0, m, s};
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n    = 1'b0;
        mval     = 1'b0;
        axi.rdy  = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_check(input string n, input logic [7:0] m, input logic [63:0] exp_b1);
        int lat;
        mval = 1'b1; mask = m; axi.rdy = 1'b1;
        tick();
        mval = 1'b0;
        lat  = 1;
        while (!axi.val && lat < 20) begin
            tick();
            lat++;
        end
        chk({n, " latency"}, 64'(lat), 64'd2);
        chk({n, " b0 sop/eop"}, 64'({axi.sop, axi.eop}), 64'b10);
        chk({n, " b0 dat"}, axi.dat, HDR_DAT);
        tick();
        chk({n, " b1 flags"}, 64'({axi.val, axi.sop, axi.eop, axi.mod, axi.ctl, axi.err}), 64'b1_0_1_000_0_0);
        chk({n, " b1 dat"}, axi.dat, exp_b1);
        tick();
        chk({n, " idle after"}, 64'(axi.val), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[4];
        logic [39:0] q[$];
        logic [31:0] mseq;
        logic [63:0] pdat;
        logic [2:0]  pflags;
        bit          movf, stall, inpkt, pop, full;
        int          w;

        tbl[0] = '{8'hFF, 64'h0000_00FF_0000_0000};
        tbl[1] = '{8'h01, 64'h0000_0001_0000_0001};
        tbl[2] = '{8'h00, 64'h0000_0000_0000_0002};
        tbl[3] = '{8'hA5, 64'h0000_00A5_0000_0003};

        // reset state
        axi.rdy = 1'b1;
        #12;
        chk("reset flags", 64'({axi.val, axi.sop, axi.eop, axi.ctl, axi.err}), 64'd0);
        chk("reset dat/mod", {axi.dat[63:3], axi.dat[2:0] | axi.mod}, 64'd0);
        chk("reset ovf/pend", 64'({ovf, pend}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mval = 1'b1; mask = 8'hAA;
        tick();
        mval = 1'b0;
        chk("strobe at reset release ignored", 64'(pend), 64'd0);
        tick();
        send_check("single pass", 8'h00, 64'h0);

        reset_dut();
        for (int i = 0; i < 4; i++) send_check($sformatf("table%0d", i), tbl[i].m, tbl[i].b1);

        // back-pressure on beat 0
        reset_dut();
        axi.rdy = 1'b0; mval = 1'b1; mask = 8'h42;
        tick();
        mval = 1'b0;
        w = 0;
        while (!axi.val && w < 20) begin tick(); w++; end
        for (int i = 0; i < 10; i++) begin
            chk("bp hold flags", 64'({axi.val, axi.sop, axi.eop}), 64'b110);
            chk("bp hold dat", axi.dat, HDR_DAT);
            chk("bp pending", 64'(pend), 64'd1);
            tick();
        end
        axi.rdy = 1'b1;
        tick();
        chk("bp b1 dat", axi.dat, body(32'd0, 8'h42));
        chk("bp pending at b1", 64'(pend), 64'd1);
        tick();
        chk("bp pending drained", 64'({axi.val, pend}), 64'd0);

        // overflow: five strobes into a depth-4 FIFO with the sink stalled
        reset_dut();
        axi.rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mval = 1'b1; mask = 8'h10 + 8'(i);
            tick();
            if (i == 3) chk("ovf before 5th", 64'({ovf, pend}), 64'({1'b0, 3'd4}));
        end
        mval = 1'b0;
        chk("ovf after 5th", 64'({ovf, pend}), 64'({1'b1, 3'd4}));
        axi.rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf drain val", 64'(axi.val), 64'd1);
            if (i % 2 == 1) chk("ovf drain b1", axi.dat, body(32'(i / 2), 8'h10 + 8'(i / 2)));
            tick();
        end
        chk("ovf drained", 64'({axi.val, pend}), 64'd0);
        chk("ovf sticky", 64'(ovf), 64'd1);
        send_check("after ovf seq5", 8'h55, body(32'd5, 8'h55));

        // full FIFO with a push in the same cycle as a pop
        reset_dut();
        axi.rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mval = 1'b1; mask = 8'h20 + 8'(i);
            tick();
        end
        mval = 1'b0; axi.rdy = 1'b1;
        tick();
        chk("full+pop in body", 64'({axi.val, axi.eop, pend}), 64'({2'b11, 3'd4}));
        mval = 1'b1; mask = 8'h77;
        tick();
        mval = 1'b0;
        chk("full+pop ovf", 64'(ovf), 64'd0);
        chk("full+pop pending", 64'(pend), 64'd4);
        for (int k = 1; k <= 4; k++) begin
            chk("full+pop b0", 64'({axi.val, axi.sop}), 64'b11);
            tick();
            chk("full+pop b1", axi.dat, body(32'(k), (k == 4) ? 8'h77 : 8'h20 + 8'(k)));
            tick();
        end

        // reset mid-packet
        reset_dut();
        mval = 1'b1; mask = 8'h09;
        tick();
        mval = 1'b0;
        tick();
        chk("mid-rst b0", 64'({axi.val, axi.sop}), 64'b11);
        tick();
        chk("mid-rst in body", 64'({axi.eop, pend}), 64'({1'b1, 3'd1}));
        #2 rst_n = 1'b0;
        #1;
        chk("mid-rst flags", 64'({axi.val, axi.sop, axi.eop, axi.ctl, axi.err, axi.mod}), 64'd0);
        chk("mid-rst dat", axi.dat, 64'd0);
        chk("mid-rst ovf/pend", 64'({ovf, pend}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        send_check("post-rst seq0", 8'h3C, body(32'd0, 8'h3C));

        // randomized run against a queue model
        reset_dut();
        mseq = 0; movf = 0; stall = 0; inpkt = 0; pdat = '0; pflags = '0;
        for (int c = 0; c < 3000; c++) begin
            axi.rdy = ((c / 64) % 2 == 1) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 9);
            mval    = ($urandom_range(0, 3) == 0);
            mask    = 8'($urandom);
            if (stall) begin
                chk("rnd stall flags", 64'({axi.val, axi.sop, axi.eop}), 64'(pflags));
                chk("rnd stall dat", axi.dat, pdat);
            end
            if (inpkt) chk("rnd beat1 follows", 64'({axi.val, axi.eop}), 64'b11);
            if (axi.val && axi.sop) chk("rnd hdr", axi.dat, HDR_DAT);
            if (axi.val) chk("rnd val only when queued", 64'(q.size() != 0), 64'd1);
            full = (q.size() == 4);
            pop  = axi.val && axi.rdy && axi.eop;
            if (pop) begin
                chk("rnd pop nonempty", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    chk("rnd body", axi.dat, body(q[0][39:8], q[0][7:0]));
                    void'(q.pop_front());
                end
            end
            if (mval) begin
                if (!full || pop) q.push_back({mseq, mask});
                else movf = 1'b1;
                mseq++;
            end
            if (axi.val && axi.rdy && axi.sop) inpkt = 1'b1;
            else if (pop) inpkt = 1'b0;
            stall  = axi.val && !axi.rdy;
            pdat   = axi.dat;
            pflags = {axi.val, axi.sop, axi.eop};
            tick();
            chk("rnd pending", 64'(pend), 64'(q.size()));
            chk("rnd overflow", 64'(ovf), 64'(movf));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/equihash_result_tx.md
# equihash_result_tx

Return-path packetiser for the Equihash verifier. Accepts one solution-check result per `i_mask_val` pulse from `equihash_verif_top`, buffers it in a small FIFO and transmits it to the host as a two-beat AXI-stream reply packet. The packet carries a sequence number. It sits between the verifier's `o_mask`/`o_mask_val` outputs and the host-facing stream mux. It is the transmit counterpart of the header stream that feeds the verifier.

## Interface
- `DAT_BYTS`, 8, stream width in bytes; only 8 is supported.
- `MASK_BITS`, 8, width of the verifier's `equihash_bm_t` mask; must be ≤ 32.
- `DEPTH`, 4, result FIFO depth in entries; must be a power of two, ≥ 2.
- `MSG_TYPE`, 32'h0000_0002, reply message-type code placed in beat 0.
- `i_clk`  in  1  sole clock; all logic is on its rising edge.
- `i_rst_n`  in  1  reset; **one clock; reset is asynchronous and active-low.**
- `i_mask`  in  `MASK_BITS`  verifier error mask; all-zero means the solution passed.
- `i_mask_val`  in  1  single-cycle strobe qualifying `i_mask`; there is no back-pressure to the verifier.
- `o_axi`  out  `if_axi_stream` source, `DAT_BYTS`=8; fields used:
  - `val`, `sop`, `eop`, `dat[63:0]`, `mod[2:0]`, `ctl`, `err` are driven by this block.
  - `rdy` is an input to this block.
- `o_overflow`  out  1  sticky: a result was dropped because the FIFO was full.
- `o_pending`  out  `$clog2(DEPTH)+1`  number of results queued and not yet fully sent. A packet in flight still counts until its beat 1 handshake.

## Operation
- **Enqueue:** on `i_mask_val`, write `{seq, i_mask}` into the FIFO, then increment `seq` (32-bit, wraps 0xFFFF_FFFF → 0).
- **Full FIFO:** the entry is dropped and `o_overflow` is set. `seq` still increments, so the host sees a sequence gap.
- **Exception to full:** if the FIFO is full but a pop (beat 1 handshake) happens in the same cycle, the push is accepted and no overflow is flagged.
- **Packet format:** all beats have `ctl`=0, `err`=0, `mod`=0 (all 8 bytes valid).
  - Beat 0: `sop`=1, `eop`=0; `dat[31:0]`=32'd16 (packet length in bytes); `dat[63:32]`=`MSG_TYPE`.
  - Beat 1: `sop`=0, `eop`=1; `dat[31:0]`=seq; `dat[32+MASK_BITS-1:32]`=mask; remaining bits 0.
- **FSM states:** IDLE, HDR, BODY.
  - IDLE → HDR when the FIFO is non-empty. `val` is asserted with beat 0 registered on the next cycle.
  - HDR → BODY on `val && rdy`.
  - BODY → pop the FIFO on `val && rdy`. Next state is HDR if another entry remains after the pop (back-to-back, no idle cycle), otherwise IDLE.
- **Stream rules:**
  - While `val && !rdy`, `dat`/`sop`/`eop`/`mod` hold stable and `val` stays high.
  - `val` never drops mid-packet.
- **Reset values:** asserting `i_rst_n` low at any time, including mid-packet, immediately clears:
  - `val`, `sop`, `eop`, `ctl`, `err` = 0; `dat` = 0; `mod` = 0;
  - `o_overflow` = 0; `o_pending` = 0; FIFO emptied; `seq` = 0; FSM = IDLE.
  - A truncated packet is not resumed.
- **After reset:** `i_mask_val` is ignored in the cycle reset deasserts.

## Timing
- **Latency:** `i_mask_val` in cycle N (empty FIFO, IDLE) → `o_axi.val`+`sop` in cycle N+2.
  - With `rdy` held high, beat 1 appears in N+3.
- **Throughput:** with `rdy` high, one packet per 2 cycles sustained. The verifier rate is far lower, so overflow only arises from sink back-pressure.
- **`o_pending` update:** registered. It increments the cycle after an accepted push and decrements the cycle after the beat 1 handshake. Simultaneous push and pop leaves it unchanged.
- **`o_overflow`:** rises the cycle after the dropped strobe.

## Test plan
- **Single pass result:** reset, `i_mask`=0, one `i_mask_val`, `rdy`=1.
  - Beat 0 `dat`=64'h0000_0002_0000_0010, `sop`=1.
  - Beat 1 `dat`=64'h0, `eop`=1, `mod`=0.
  - First `val` is 2 cycles after the strobe.
- **Failing mask and seq increment:** two strobes with `i_mask`=8'hFF then 8'h01.
  - Beat 1 `dat` values are 64'h0000_00FF_0000_0000 then 64'h0000_0001_0000_0001.
- **Back-pressure:** `rdy`=0 for 10 cycles after beat 0 appears.
  - Beat 0 stays stable with `val`=1 throughout.
  - On release the packet completes intact; `o_pending` = 1 until beat 1 is accepted.
- **Overflow:** `rdy`=0, 5 strobes with `DEPTH`=4.
  - `o_overflow`=1 after the 5th strobe; `o_pending`=4.
  - Release `rdy`: 4 packets back-to-back (8 consecutive `val` cycles) with seq 0,1,2,3. Seq 4 is absent.
  - Next strobe sends seq 5.
- **Full FIFO with simultaneous pop:** FIFO full; strobe in the same cycle as a beat 1 handshake.
  - Push accepted, `o_overflow` stays 0, `o_pending` stays 4.
- **Reset mid-packet:** assert `i_rst_n` low after beat 0 is accepted.
  - All outputs 0 asynchronously.
  - After release, the next strobe produces a packet with seq 0.
